// File: rtl/vtiming_pkg.sv
// Shared types, default timing and sizing helpers for the vertical timing generator.
package vtiming_pkg;

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    ACTIVE      = 2'd2,
    FRONT_PORCH = 2'd3
  } vtg_state_t;

  localparam int unsigned DEF_CLKS_PER_LINE = 1600;
  localparam int unsigned DEF_SYNC_LINES    = 2;
  localparam int unsigned DEF_BP_LINES      = 29;
  localparam int unsigned DEF_ACTIVE_LINES  = 480;
  localparam int unsigned DEF_FP_LINES      = 10;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/vtg_line_timer.sv
// Pixel-clock counter within one scan line; flags the last clock of the line.
module vtg_line_timer
  import vtiming_pkg::*;
#(
  parameter int unsigned CLKS_PER_LINE = DEF_CLKS_PER_LINE,
  localparam int unsigned PIX_W = $clog2(CLKS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [PIX_W-1:0] pix_cnt_o,
  output logic             line_end_o
);

  logic [PIX_W-1:0] pix_q, pix_d;

  assign line_end_o = en_i && (pix_q == PIX_W'(CLKS_PER_LINE - 1));
  assign pix_cnt_o  = pix_q;

  always_comb begin
    pix_d = pix_q;
    if (en_i) begin
      pix_d = line_end_o ? '0 : pix_q + PIX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

endmodule

// File: rtl/vtiming_gen.sv
// Vertical timing generator: phase FSM, scaled row address and frame counter,
// all registered so outputs line up with the line timer's pixel count.
module vtiming_gen
  import vtiming_pkg::*;
#(
  parameter int unsigned CLKS_PER_LINE = DEF_CLKS_PER_LINE,
  parameter int unsigned SYNC_LINES    = DEF_SYNC_LINES,
  parameter int unsigned BP_LINES      = DEF_BP_LINES,
  parameter int unsigned ACTIVE_LINES  = DEF_ACTIVE_LINES,
  parameter int unsigned FP_LINES      = DEF_FP_LINES,
  parameter int unsigned SCALE         = 1,
  parameter logic        SYNC_POL      = 1'b0,
  parameter int unsigned ADDR_W        = ((ACTIVE_LINES / SCALE) > 1) ?
                                         $clog2(ACTIVE_LINES / SCALE) : 1,
  parameter int unsigned FRAME_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  output logic               vsync_o,
  output logic               display_area_o,
  output logic               vblank_o,
  output logic [ADDR_W-1:0]  vaddr_o,
  output logic               line_tick_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_cnt_o
);

  localparam int unsigned PIX_W    = $clog2(CLKS_PER_LINE);
  localparam int unsigned LINE_MAX = max4(SYNC_LINES, BP_LINES, ACTIVE_LINES, FP_LINES);
  localparam int unsigned LINE_W   = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int unsigned REP_W    = $clog2(SCALE) + 1;

  if (ACTIVE_LINES % SCALE != 0) begin : g_bad_scale
    $error("vtiming_gen: ACTIVE_LINES must be a multiple of SCALE");
  end

  logic [PIX_W-1:0] pix_cnt;
  logic             line_end;

  vtg_line_timer #(
    .CLKS_PER_LINE(CLKS_PER_LINE)
  ) u_line_timer (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .pix_cnt_o (pix_cnt),
    .line_end_o(line_end)
  );

  vtg_state_t         state_q, state_d, next_state;
  logic [LINE_W-1:0]  line_q, line_d, last_line;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [ADDR_W-1:0]  vaddr_q, vaddr_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic               vsync_q, vsync_d;
  logic               disp_q, disp_d;
  logic               tick_q, tick_d;
  logic               fstart_q, fstart_d;

  always_comb begin
    last_line  = LINE_W'(SYNC_LINES - 1);
    next_state = BACK_PORCH;
    unique case (state_q)
      SYNC:        begin last_line = LINE_W'(SYNC_LINES - 1);   next_state = BACK_PORCH;  end
      BACK_PORCH:  begin last_line = LINE_W'(BP_LINES - 1);     next_state = ACTIVE;      end
      ACTIVE:      begin last_line = LINE_W'(ACTIVE_LINES - 1); next_state = FRONT_PORCH; end
      FRONT_PORCH: begin last_line = LINE_W'(FP_LINES - 1);     next_state = SYNC;        end
    endcase
  end

  // Pulse registers hold while paused; the outputs are gated by en_i instead.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    rep_d    = rep_q;
    vaddr_d  = vaddr_q;
    fcnt_d   = fcnt_q;
    vsync_d  = vsync_q;
    disp_d   = disp_q;
    tick_d   = tick_q;
    fstart_d = fstart_q;
    if (en_i) begin
      tick_d   = (pix_cnt == PIX_W'(CLKS_PER_LINE - 2));
      fstart_d = 1'b0;
      if (line_end) begin
        if (line_q == last_line) begin
          line_d  = '0;
          state_d = next_state;
          if (state_q == FRONT_PORCH) begin
            fstart_d = 1'b1;
            fcnt_d   = fcnt_q + FRAME_W'(1);
          end
        end else begin
          line_d = line_q + LINE_W'(1);
        end
        if (state_q == ACTIVE) begin
          if (rep_q == REP_W'(SCALE - 1)) begin
            rep_d   = '0;
            vaddr_d = vaddr_q + ADDR_W'(1);
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
          if (state_d != ACTIVE) begin
            rep_d   = '0;
            vaddr_d = '0;
          end
        end
      end
      vsync_d = (state_d == SYNC) ? SYNC_POL : ~SYNC_POL;
      disp_d  = (state_d == ACTIVE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SYNC;
      line_q   <= '0;
      rep_q    <= '0;
      vaddr_q  <= '0;
      fcnt_q   <= '0;
      vsync_q  <= SYNC_POL;
      disp_q   <= 1'b0;
      tick_q   <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      rep_q    <= rep_d;
      vaddr_q  <= vaddr_d;
      fcnt_q   <= fcnt_d;
      vsync_q  <= vsync_d;
      disp_q   <= disp_d;
      tick_q   <= tick_d;
      fstart_q <= fstart_d;
    end
  end

  assign vsync_o        = vsync_q;
  assign display_area_o = disp_q;
  assign vblank_o       = ~disp_q;
  assign vaddr_o        = vaddr_q;
  assign line_tick_o    = tick_q & en_i;
  assign frame_start_o  = fstart_q & en_i;
  assign frame_cnt_o    = fcnt_q;

endmodule
